// File: rtl/vertex_flag_pkg.sv
// Shared types and flag-update helper for the vertex flag table.
// Op and FSM encodings live here so the top and bench agree.
package vertex_flag_pkg;

  localparam int FLAG_W = 8;

  localparam logic [1:0] OP_READ_ENC = 2'd0;
  localparam logic [1:0] OP_SET_ENC  = 2'd1;
  localparam logic [1:0] OP_CLR_ENC  = 2'd2;
  localparam logic [1:0] OP_TAS_ENC  = 2'd3;

  typedef enum logic [1:0] {
    OP_READ = OP_READ_ENC,
    OP_SET  = OP_SET_ENC,
    OP_CLR  = OP_CLR_ENC,
    OP_TAS  = OP_TAS_ENC
  } op_t;

  typedef enum logic [1:0] {
    INIT_SWEEP,
    RUN,
    DRAIN,
    SWEEP
  } state_t;

  function automatic logic [FLAG_W-1:0] flag_update(
    input logic [FLAG_W-1:0] old_f,
    input logic [FLAG_W-1:0] mask,
    input op_t               op
  );
    logic [FLAG_W-1:0] res;
    res = old_f;
    unique case (op)
      OP_SET, OP_TAS: res = old_f | mask;
      OP_CLR:         res = old_f & ~mask;
      default:        res = old_f;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Block RAM with read-first behaviour and registered read data.
// One write address and one read address; no reset on contents.
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 5,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
  input  logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]         dina,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_q;

  // write port plus read-first capture of the addressed word
  always_ff @(posedge clka) begin
    if (wea) mem_q[wr_addr] <= dina;
    if (ena) rd_q <= mem_q[rd_addr];
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_ll
      assign douta = rd_q;
    end else begin : g_hp
      logic [RAM_WIDTH-1:0] out_q;
      // extra output stage for high-performance mode
      always_ff @(posedge clka) out_q <= rd_q;
      assign douta = out_q;
    end
  endgenerate

endmodule

// File: rtl/vertex_flag_table.sv
// Per-vertex flag store with epoch-tagged bulk clear.
// Three-stage request pipeline with write-back forwarding.
module vertex_flag_table
  import vertex_flag_pkg::*;
#(
  parameter int PROC_BITS  = 4,
  parameter int ADDR_BITS  = 10,
  parameter int NUM_FLAGS  = 2,
  parameter int EPOCH_BITS = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic [1:0]              req_op_in,
  input  logic [32+PROC_BITS-1:0] req_addr_in,
  input  logic [NUM_FLAGS-1:0]    req_mask_in,
  input  logic [PROC_BITS-1:0]    req_id_in,
  output logic                    rsp_valid_out,
  output logic [NUM_FLAGS-1:0]    rsp_flags_out,
  output logic [PROC_BITS-1:0]    rsp_id_out,
  input  logic                    clear_all_in,
  output logic                    clear_done_out,
  output logic                    busy_out,
  output logic [EPOCH_BITS-1:0]   epoch_out
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int EW    = NUM_FLAGS + EPOCH_BITS;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic                  done_q, done_d;

  logic                  s1_valid_q, s1_valid_d;
  op_t                   s1_op_q, s1_op_d;
  logic [ADDR_BITS-1:0]  s1_idx_q, s1_idx_d;
  logic [NUM_FLAGS-1:0]  s1_mask_q, s1_mask_d;
  logic [PROC_BITS-1:0]  s1_id_q, s1_id_d;

  logic                  fwd_v_q, fwd_v_d;
  logic [ADDR_BITS-1:0]  fwd_idx_q, fwd_idx_d;
  logic [EW-1:0]         fwd_data_q, fwd_data_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [NUM_FLAGS-1:0]  rsp_flags_q, rsp_flags_d;
  logic [PROC_BITS-1:0]  rsp_id_q, rsp_id_d;

  logic                  accept;
  logic                  sweeping;
  logic [EW-1:0]         ram_dout;
  logic [EW-1:0]         raw;
  logic [NUM_FLAGS-1:0]  old_flags;
  logic [NUM_FLAGS-1:0]  new_flags;
  logic                  we;
  logic [ADDR_BITS-1:0]  waddr;
  logic [EW-1:0]         wdata;
  logic                  unused_addr;

  assign unused_addr = ^req_addr_in[32+PROC_BITS-1:ADDR_BITS];

  assign req_ready_out = !rst_in && (state_q == RUN) && !clear_all_in;
  assign accept        = req_valid_in && req_ready_out;
  assign sweeping      = (state_q == INIT_SWEEP) || (state_q == SWEEP);

  // sweep/drain sequencing and epoch advance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epoch_d = epoch_q;
    done_d  = 1'b0;
    unique case (state_q)
      INIT_SWEEP, SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          done_d  = (state_q == SWEEP);
        end
      end
      RUN: begin
        if (clear_all_in) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_BITS'(1)) begin
          cnt_d   = '0;
          epoch_d = epoch_q + 1'b1;
          if (epoch_q == '1) begin
            state_d = SWEEP;
          end else begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = INIT_SWEEP;
    endcase
  end

  // S0 capture, S1 modify/write-back, S2 response
  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = op_t'(req_op_in);
    s1_idx_d   = req_addr_in[ADDR_BITS-1:0];
    s1_mask_d  = req_mask_in;
    s1_id_d    = req_id_in;

    raw = (fwd_v_q && (fwd_idx_q == s1_idx_q)) ? fwd_data_q : ram_dout;
    old_flags = (raw[EW-1:NUM_FLAGS] == epoch_q) ?
                raw[NUM_FLAGS-1:0] : '0;
    new_flags = NUM_FLAGS'(flag_update(FLAG_W'(old_flags),
                                       FLAG_W'(s1_mask_q), s1_op_q));

    we    = sweeping || (s1_valid_q && (s1_op_q != OP_READ));
    waddr = sweeping ? cnt_q : s1_idx_q;
    wdata = sweeping ? '0 : {epoch_q, new_flags};

    fwd_v_d    = we;
    fwd_idx_d  = waddr;
    fwd_data_d = wdata;

    rsp_valid_d = s1_valid_q;
    rsp_flags_d = s1_valid_q ? old_flags : '0;
    rsp_id_d    = s1_valid_q ? s1_id_q : '0;
  end

  // state and pipeline registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= INIT_SWEEP;
      cnt_q       <= '0;
      epoch_q     <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_READ;
      s1_idx_q    <= '0;
      s1_mask_q   <= '0;
      s1_id_q     <= '0;
      fwd_v_q     <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_flags_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      epoch_q     <= epoch_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_idx_q    <= s1_idx_d;
      s1_mask_q   <= s1_mask_d;
      s1_id_q     <= s1_id_d;
      fwd_v_q     <= fwd_v_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH      (EW),
    .RAM_DEPTH      (DEPTH),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_ram (
    .clka   (clk_in),
    .ena    (accept),
    .wea    (we),
    .wr_addr(waddr),
    .rd_addr(req_addr_in[ADDR_BITS-1:0]),
    .dina   (wdata),
    .douta  (ram_dout)
  );

  assign rsp_valid_out  = rsp_valid_q;
  assign rsp_flags_out  = rsp_flags_q;
  assign rsp_id_out     = rsp_id_q;
  assign clear_done_out = done_q;
  assign busy_out       = !rst_in && (state_q != RUN);
  assign epoch_out      = epoch_q;

endmodule

// File: tb/tb_vertex_flag_table.sv
// Scoreboard bench for vertex_flag_table.
// Reference model keeps plain flag values and clears them outright.
module tb_vertex_flag_table;

  localparam int PB    = 4;
  localparam int AB    = 10;
  localparam int NF    = 2;
  localparam int EB    = 3;
  localparam int DEPTH = 1024;

  localparam logic [1:0] RD  = 2'd0;
  localparam logic [1:0] ST  = 2'd1;
  localparam logic [1:0] CL  = 2'd2;
  localparam logic [1:0] TAS = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [35:0]   req_addr = '0;
  logic [NF-1:0] req_mask = '0;
  logic [PB-1:0] req_id = '0;
  logic          rsp_valid;
  logic [NF-1:0] rsp_flags;
  logic [PB-1:0] rsp_id;
  logic          clear_all = 1'b0;
  logic          clear_done;
  logic          busy;
  logic [EB-1:0] epoch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [NF-1:0] model [DEPTH];
  int            model_epoch = 0;

  logic [NF-1:0] q_flags [$];
  logic [PB-1:0] q_id [$];
  int            q_cyc [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vertex_flag_table #(
    .PROC_BITS (PB),
    .ADDR_BITS (AB),
    .NUM_FLAGS (NF),
    .EPOCH_BITS(EB)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_op_in     (req_op),
    .req_addr_in   (req_addr),
    .req_mask_in   (req_mask),
    .req_id_in     (req_id),
    .rsp_valid_out (rsp_valid),
    .rsp_flags_out (rsp_flags),
    .rsp_id_out    (rsp_id),
    .clear_all_in  (clear_all),
    .clear_done_out(clear_done),
    .busy_out      (busy),
    .epoch_out     (epoch)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor: pop expected responses as the DUT presents them
  always @(negedge clk) begin
    if (rst) begin
      check("rsp_valid_in_reset", {63'd0, rsp_valid}, 64'd0);
    end else if (rsp_valid) begin
      if (q_flags.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got flags %0h id %0h expected none",
                 rsp_flags, rsp_id);
      end else begin
        check("rsp_flags", {62'd0, rsp_flags}, {62'd0, q_flags.pop_front()});
        check("rsp_id", {60'd0, rsp_id}, {60'd0, q_id.pop_front()});
        check("rsp_cycle", 64'(cyc), 64'(q_cyc.pop_front()));
      end
    end else if (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rsp: got none expected flags %0h at cycle %0d",
               q_flags[0], q_cyc[0]);
      void'(q_flags.pop_front());
      void'(q_id.pop_front());
      void'(q_cyc.pop_front());
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [35:0] addr,
                       input logic [NF-1:0] mask, input logic [PB-1:0] id);
    int            a;
    logic [NF-1:0] old;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_mask  = mask;
    req_id    = id;
    clear_all = 1'b0;
    #1;
    if (req_ready) begin
      a   = int'(addr % 36'd1024);
      old = model[a];
      if (op == ST || op == TAS) model[a] = old | mask;
      if (op == CL) model[a] = old & ~mask;
      q_flags.push_back(old);
      q_id.push_back(id);
      q_cyc.push_back(cyc + 2);
    end else begin
      checks++;
      errors++;
      $display("FAIL req_ready: got 0 expected 1 (cycle %0d)", cyc);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic init_count();
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("init_busy_len", 64'(n), 64'd1024);
    check("init_ready", {63'd0, req_ready}, 64'd1);
    check("init_epoch", {61'd0, epoch}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs",
          {57'd0, rsp_valid, rsp_flags, rsp_id, req_ready, busy,
           clear_done, epoch},
          64'd0);
    q_flags.delete();
    q_id.delete();
    q_cyc.delete();
    model_clear();
    model_epoch = 0;
    req_valid = 1'b0;
    clear_all = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    init_count();
  endtask

  task automatic do_clear();
    int n = 0;
    bit wrap;
    wrap      = (model_epoch == 7);
    req_valid = 1'b1;
    req_op    = TAS;
    req_addr  = 36'($urandom_range(0, 15));
    req_mask  = 2'b11;
    req_id    = 4'hF;
    clear_all = 1'b1;
    #1;
    check("ready_vs_clear", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    clear_all = 1'b0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("clear_busy_len", 64'(n), wrap ? 64'd1026 : 64'd2);
    check("clear_done", {63'd0, clear_done}, 64'd1);
    model_clear();
    model_epoch = (model_epoch + 1) % 8;
    check("epoch", {61'd0, epoch}, 64'(model_epoch));
    @(negedge clk);
    check("clear_done_pulse", {63'd0, clear_done}, 64'd0);
  endtask

  initial begin
    logic [35:0] ad;
    int          r;
    model_clear();
    #2;
    check("reset_outputs0",
          {57'd0, rsp_valid, rsp_flags, rsp_id, req_ready, busy,
           clear_done, epoch},
          64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    init_count();

    issue(TAS, 36'd5, 2'b01, 4'd1);
    issue(TAS, 36'd5, 2'b01, 4'd2);
    issue(RD, 36'd5, 2'b00, 4'd3);
    idle(1);

    issue(ST, 36'd7, 2'b10, 4'd4);
    issue(CL, 36'd7, 2'b10, 4'd5);
    issue(RD, 36'd7, 2'b11, 4'd6);
    issue(ST, 36'd7, 2'b01, 4'd7);
    issue(RD, 36'h407, 2'b00, 4'd8);
    issue(RD, 36'hF_0000_0007, 2'b00, 4'd9);
    idle(2);

    issue(ST, 36'd3, 2'b11, 4'd10);
    idle(2);
    do_clear();
    issue(RD, 36'd3, 2'b00, 4'd11);
    idle(3);

    issue(TAS, 36'd9, 2'b01, 4'd1);
    issue(TAS, 36'd9, 2'b10, 4'd2);
    issue(TAS, 36'd9, 2'b01, 4'd3);
    req_valid = 1'b1;
    req_op    = TAS;
    req_addr  = 36'd9;
    req_mask  = 2'b11;
    @(posedge clk);
    #2;
    do_reset();

    issue(ST, 36'd1, 2'b01, 4'd1);
    issue(ST, 36'd2, 2'b10, 4'd2);
    issue(ST, 36'd3, 2'b11, 4'd3);
    idle(3);
    for (int k = 0; k < 8; k++) do_clear();
    issue(RD, 36'd1, 2'b00, 4'd4);
    issue(RD, 36'd2, 2'b00, 4'd5);
    issue(RD, 36'd3, 2'b00, 4'd6);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_clear();
      end else if (r < 15) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 3) == 0)
          ad = {4'($urandom), 32'($urandom)};
        else
          ad = 36'($urandom_range(0, 15)) + (36'($urandom) << 10);
        issue(2'($urandom), ad, 2'($urandom), 4'($urandom));
      end
    end
    idle(5);
    check("queue_drained", 64'(q_cyc.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
